// File: rtl/route_pkg.sv
// Shared types and helpers for the demux routing controller.
// Optional per-port counters are enabled with ROUTE_CTRL_COUNT_EN.
package route_pkg;

    localparam int COUNT_W = 16;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } route_state_e;

    function automatic int dest_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/route_pipe_buf.sv
// One-entry pipelined val/rdy buffer: accepts a new entry in the same cycle
// the held entry drains, so it sustains one transfer per cycle.
module route_pipe_buf
    import route_pkg::*;
#(
    parameter int p_width = 8
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic               enq_val,
    output logic               enq_rdy,
    input  logic [p_width-1:0] enq_data,
    output logic               deq_val,
    input  logic               deq_rdy,
    output logic [p_width-1:0] deq_data
);

    route_state_e       state;
    route_state_e       state_next;
    logic [p_width-1:0] data_reg;
    logic               enq_xfer;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_EMPTY;
            data_reg <= '0;
        end else begin
            state <= state_next;
            if (enq_xfer) begin
                data_reg <= enq_data;
            end
        end
    end

    // A full buffer frees its slot on deq_rdy, which is what lets a refill happen in the same cycle.
    always_comb begin
        state_next = state;
        deq_val    = 1'b0;
        enq_rdy    = 1'b1;
        enq_xfer   = 1'b0;
        case (state)
            ST_EMPTY: begin
                enq_xfer = enq_val;
                if (enq_val) begin
                    state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                deq_val  = 1'b1;
                enq_rdy  = deq_rdy;
                enq_xfer = enq_val && deq_rdy;
                if (deq_rdy && !enq_val) begin
                    state_next = ST_EMPTY;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    assign deq_data = data_reg;

endmodule

// File: rtl/demux_route_ctrl.sv
// 1-to-N packet router: decodes the header destination, buffers one packet and
// presents it on one output port. ROUTE_CTRL_COUNT_EN adds pkt_count/drop_count.
module demux_route_ctrl
    import route_pkg::*;
#(
    parameter int p_nbits    = 8,
    parameter int p_noutputs = 4
)
(
    input  logic                           clk,
    input  logic                           reset,
    input  logic [p_nbits-1:0]             recv_msg,
    input  logic                           recv_val,
    output logic                           recv_rdy,
    output logic [p_noutputs*p_nbits-1:0]  send_msg,
    output logic [p_noutputs-1:0]          send_val,
    input  logic [p_noutputs-1:0]          send_rdy,
    output logic                           drop_err
`ifdef ROUTE_CTRL_COUNT_EN
    ,
    output logic [p_noutputs*COUNT_W-1:0]  pkt_count,
    output logic [COUNT_W-1:0]             drop_count
`endif
);

    localparam int DW = dest_width(p_noutputs);

    logic [DW-1:0]         recv_dest;
    logic                  dest_ok;
    logic                  recv_xfer;
    logic                  buf_enq_val;
    logic                  buf_enq_rdy;
    logic                  buf_deq_val;
    logic                  buf_deq_rdy;
    logic [DW+p_nbits-1:0] buf_deq_data;
    logic [DW-1:0]         buf_dest;
    logic [p_nbits-1:0]    buf_msg;
    logic                  drop_reg;

    assign recv_dest   = recv_msg[p_nbits-1 -: DW];
    assign dest_ok     = int'(recv_dest) < p_noutputs;
    assign recv_rdy    = !reset && buf_enq_rdy;
    assign recv_xfer   = recv_val && recv_rdy;
    assign buf_enq_val = recv_val && dest_ok;
    assign buf_dest    = buf_deq_data[DW+p_nbits-1 -: DW];
    assign buf_msg     = buf_deq_data[p_nbits-1:0];

    route_pipe_buf #(
        .p_width (DW + p_nbits)
    ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .enq_val  (buf_enq_val),
        .enq_rdy  (buf_enq_rdy),
        .enq_data ({recv_dest, recv_msg}),
        .deq_val  (buf_deq_val),
        .deq_rdy  (buf_deq_rdy),
        .deq_data (buf_deq_data)
    );

    // Only the selected port's ready reaches the buffer; all other ports see zeros.
    always_comb begin
        send_val    = '0;
        send_msg    = '0;
        buf_deq_rdy = 1'b0;
        for (int i = 0; i < p_noutputs; i++) begin
            if (int'(buf_dest) == i) begin
                buf_deq_rdy = send_rdy[i];
                if (buf_deq_val && !reset) begin
                    send_val[i] = 1'b1;
                    send_msg[(p_noutputs-1-i)*p_nbits +: p_nbits] = buf_msg;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_reg <= 1'b0;
        end else begin
            drop_reg <= recv_xfer && !dest_ok;
        end
    end

    assign drop_err = drop_reg && !reset;

`ifdef ROUTE_CTRL_COUNT_EN
    localparam logic [COUNT_W-1:0] CNT_ONE = 1;

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_count  <= '0;
            drop_count <= '0;
        end else begin
            for (int i = 0; i < p_noutputs; i++) begin
                if (send_val[i] && send_rdy[i]) begin
                    pkt_count[i*COUNT_W +: COUNT_W] <= pkt_count[i*COUNT_W +: COUNT_W] + CNT_ONE;
                end
            end
            if (recv_xfer && !dest_ok) begin
                drop_count <= drop_count + CNT_ONE;
            end
        end
    end
`endif

endmodule

// File: tb/tb_demux_route_ctrl.sv
// Randomized self-checking bench for demux_route_ctrl (3 ports, 8-bit packets)
// against a cycle-level packet model; counters checked when ROUTE_CTRL_COUNT_EN is defined.
module tb_demux_route_ctrl;

    localparam int NB = 8;
    localparam int NO = 3;

    logic             clk;
    logic             reset;
    logic [NB-1:0]    recv_msg;
    logic             recv_val;
    logic             recv_rdy;
    logic [NO*NB-1:0] send_msg;
    logic [NO-1:0]    send_val;
    logic [NO-1:0]    send_rdy;
    logic             drop_err;
`ifdef ROUTE_CTRL_COUNT_EN
    logic [NO*16-1:0] pkt_count;
    logic [15:0]      drop_count;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: at most one buffered packet plus a pending drop flag.
    bit          m_full;
    logic [7:0]  m_msg;
    int          m_dest;
    bit          m_drop_pend;
    logic [15:0] m_pkt_cnt [NO];
    logic [15:0] m_drop_cnt;

    demux_route_ctrl #(
        .p_nbits    (NB),
        .p_noutputs (NO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .recv_msg   (recv_msg),
        .recv_val   (recv_val),
        .recv_rdy   (recv_rdy),
        .send_msg   (send_msg),
        .send_val   (send_val),
        .send_rdy   (send_rdy),
        .drop_err   (drop_err)
`ifdef ROUTE_CTRL_COUNT_EN
        ,
        .pkt_count  (pkt_count),
        .drop_count (drop_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, actual, expected);
        end
    endtask

    // Drives one cycle of inputs, checks outputs at the falling edge, then advances the model.
    task automatic applyStimulus(input logic [NB-1:0] msg, input logic val,
                                 input logic [NO-1:0] rdy, input logic rst);
        logic [NO*NB-1:0] exp_msg;
        logic [NO-1:0]    exp_val;
        logic             exp_rdy;
        logic             exp_drop;
        int               dest;
        bit               sent;
        bit               accept;

        reset    = rst;
        recv_msg = msg;
        recv_val = val;
        send_rdy = rdy;
        @(negedge clk);

        exp_msg  = '0;
        exp_val  = '0;
        exp_rdy  = 1'b0;
        exp_drop = 1'b0;
        if (!rst) begin
            if (m_full) begin
                exp_val[m_dest] = 1'b1;
                exp_msg[(NO-1-m_dest)*NB +: NB] = m_msg;
            end
            exp_rdy  = !m_full || rdy[m_dest];
            exp_drop = m_drop_pend;
        end
        checkOutput("send_val", 64'(send_val), 64'(exp_val));
        checkOutput("send_msg", 64'(send_msg), 64'(exp_msg));
        checkOutput("recv_rdy", 64'(recv_rdy), 64'(exp_rdy));
        checkOutput("drop_err", 64'(drop_err), 64'(exp_drop));
`ifdef ROUTE_CTRL_COUNT_EN
        for (int i = 0; i < NO; i++) begin
            checkOutput($sformatf("pkt_count%0d", i), 64'(pkt_count[i*16 +: 16]), 64'(m_pkt_cnt[i]));
        end
        checkOutput("drop_count", 64'(drop_count), 64'(m_drop_cnt));
`endif

        if (rst) begin
            m_full      = 0;
            m_drop_pend = 0;
            for (int i = 0; i < NO; i++) m_pkt_cnt[i] = '0;
            m_drop_cnt  = '0;
        end else begin
            dest   = int'(msg) / (1 << (NB - 2));
            sent   = m_full && rdy[m_dest];
            accept = val && exp_rdy;
            if (sent) begin
                m_pkt_cnt[m_dest] = m_pkt_cnt[m_dest] + 16'd1;
                m_full = 0;
            end
            m_drop_pend = accept && (dest >= NO);
            if (m_drop_pend) m_drop_cnt = m_drop_cnt + 16'd1;
            if (accept && dest < NO) begin
                m_full = 1;
                m_msg  = msg;
                m_dest = dest;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        m_full = 0;
        m_dest = 0;
        m_msg  = '0;
        applyStimulus(8'h00, 1'b0, 3'b111, 1'b1);
        applyStimulus(8'h00, 1'b1, 3'b111, 1'b1);

        // single packet to port 2
        applyStimulus(8'h8A, 1'b1, 3'b111, 1'b0);
        applyStimulus(8'h00, 1'b0, 3'b111, 1'b0);
        applyStimulus(8'h00, 1'b0, 3'b111, 1'b0);

        // back-to-back to ports 0, 1, 2, then an invalid dest
        applyStimulus(8'h05, 1'b1, 3'b111, 1'b0);
        applyStimulus(8'h45, 1'b1, 3'b111, 1'b0);
        applyStimulus(8'h85, 1'b1, 3'b111, 1'b0);
        applyStimulus(8'hC5, 1'b1, 3'b111, 1'b0);
        applyStimulus(8'hC0, 1'b1, 3'b111, 1'b0);
        applyStimulus(8'h00, 1'b0, 3'b111, 1'b0);

        // backpressure on port 1 for three cycles, then drain with a new accept
        applyStimulus(8'h4F, 1'b1, 3'b101, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(8'h11, 1'b1, 3'b101, 1'b0);
        applyStimulus(8'h11, 1'b1, 3'b111, 1'b0);
        applyStimulus(8'h00, 1'b0, 3'b111, 1'b0);

        // reset while stalled discards the buffered packet
        applyStimulus(8'h4A, 1'b1, 3'b000, 1'b0);
        applyStimulus(8'h00, 1'b0, 3'b000, 1'b0);
        applyStimulus(8'h00, 1'b0, 3'b000, 1'b1);
        applyStimulus(8'h00, 1'b0, 3'b111, 1'b0);
        applyStimulus(8'h00, 1'b0, 3'b111, 1'b0);

        for (int i = 0; i < 500; i++) begin
            applyStimulus(NB'($urandom), 1'($urandom_range(0, 3) != 0),
                          NO'($urandom), 1'($urandom_range(0, 60) == 0));
        end

`ifdef ROUTE_CTRL_COUNT_EN
        applyStimulus(8'h00, 1'b0, 3'b111, 1'b1);
        for (int i = 0; i < 65536; i++) applyStimulus(8'h01, 1'b1, 3'b111, 1'b0);
        applyStimulus(8'h00, 1'b0, 3'b111, 1'b0);
        applyStimulus(8'h00, 1'b0, 3'b111, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/demux_route_ctrl.md
# demux_route_ctrl

Routing controller that sequences a 1-to-N demux datapath in the packet routing interconnect. Accepts packets on a single val/rdy input stream and decodes the destination field from the packet header. Holds each packet in a one-entry pipelined buffer and presents it on exactly one of N val/rdy output ports. Sustains one packet per cycle when the selected output is ready, and drops packets addressed to nonexistent outputs.

## Interface
- p_nbits, 8: packet width in bits; must be ≥ $clog2(p_noutputs)+1.
- p_noutputs, 4: number of output ports; ≥ 2, need not be a power of two.
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- recv_msg  input  p_nbits  incoming packet; destination = recv_msg[p_nbits-1 -: $clog2(p_noutputs)].
- recv_val  input  1  incoming packet valid.
- recv_rdy  output  1  controller can accept a packet this cycle.
- send_msg  output  p_noutputs*p_nbits  flattened outputs; port i occupies slice [(p_noutputs-1-i)*p_nbits +: p_nbits]; non-selected slices are all-zero.
- send_val  output  p_noutputs  per-port valid, bit i = port i; at most one bit set.
- send_rdy  input  p_noutputs  per-port ready, bit i = port i.
- drop_err  output  1  one-cycle pulse when an invalid-destination packet is consumed.

## Operation
- The controller has two states, set by the buffer valid bit: EMPTY and FULL.
- EMPTY:
  - recv_rdy=1.
  - recv_val=1 with a valid destination (dest < p_noutputs) latches msg and dest, then goes to FULL.
  - An invalid destination (dest ≥ p_noutputs) is consumed without being buffered; drop_err=1 next cycle; state stays EMPTY.
- FULL:
  - send_val[dest]=1 and slice dest of send_msg = buffered msg.
  - When send_rdy[dest]=1 the packet leaves. In that same cycle recv_rdy=1 (pipelined), so a simultaneous new accept refills the buffer and the state stays FULL. With no new accept, the state goes to EMPTY.
  - send_rdy[dest]=0 gives recv_rdy=0; msg and dest hold stable until the transfer.
- recv_rdy = !full | send_rdy[dest]. It depends combinationally on send_rdy; there is no path from recv_val to recv_rdy.
- send_rdy bits for non-selected ports are ignored.
- Handshake: a transfer occurs on an edge where val && rdy. send_val never deasserts without a transfer.

## Timing
- Latency: packet accepted at edge t is visible on send_* after edge t.
- Throughput: 1 packet/cycle with a continuously ready destination, including back-to-back packets to different ports.
- Reset:
  - While reset=1: send_val=0, recv_rdy=0, drop_err=0, send_msg=0.
  - The buffer empties on the first edge with reset high.
  - Reset mid-transfer discards the buffered packet without a send.
- First accept is possible on the first edge after reset deasserts.
- drop_err is registered: high exactly one cycle after the dropping edge. Back-to-back drops give consecutive pulses.

## Configuration
- ROUTE_CTRL_COUNT_EN defined:
  - Adds output pkt_count (p_noutputs*16 bits, port i at [i*16 +: 16]).
  - Each 16-bit counter increments on every send transfer to its port and wraps 0xFFFF→0.
  - Adds output drop_count (16 bits), incremented on each drop and also wrapping.
  - All counters reset to 0.
- ROUTE_CTRL_COUNT_EN undefined: these ports and their registers do not exist; all other behaviour is identical.

## Structure
- Shared package route_pkg holds:
  - function dest_width(n) = $clog2(n).
  - localparam COUNT_W = 16.
  - Typedef of the EMPTY/FULL state enum.
- One sub-module: route_pipe_buf, a one-entry pipelined val/rdy buffer carrying {dest, msg}.
- Destination decode, drop logic, and demux of buffer output onto send_msg/send_val live in demux_route_ctrl.

## Test plan
- Single packet: p_noutputs=4, p_nbits=8, send_rdy=4'b1111, send 0x8A (dest 2) → next cycle send_val=4'b0100, port-2 slice=0x8A, other slices 0.
- Back-to-back: 0x05, 0x45, 0xC5 on consecutive cycles, all ready → send_val 0001, 0010, 1000 on consecutive cycles; recv_rdy stays 1.
- Backpressure: dest 1 with send_rdy[1]=0 for 3 cycles → recv_rdy=0 and msg stable for 3 cycles; transfer on the 4th cycle with a simultaneous new accept.
- Invalid dest: p_noutputs=3, msg 0xC0 (dest 3) → no send_val, drop_err high one cycle; with COUNT_EN, drop_count=1.
- Reset mid-operation: buffer FULL and stalled, assert reset → send_val=0, recv_rdy=0; after release the buffered packet never appears.
- Counters (COUNT_EN): preload pkt_count[0] to 0xFFFF via 65535 sends to port 0, send one more → wraps to 0.
